// File: rtl/prowess_mem_pkg.sv
// Shared-memory geometry and the result-writer state encoding.
package prowess_mem_pkg;

   localparam int SHMEM_DEPTH = 2048;
   localparam int SHMEM_AW    = 11;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } writer_state_e;

endpackage

// File: rtl/pe_port_fifo.sv
// Small synchronous FIFO buffering words from one PE edge port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Storage is not reset; clearing the pointers is enough to drop contents.
module pe_port_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  pop,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]           wr_ptr_q, wr_ptr_d;
   logic [AW:0]           rd_ptr_q, rd_ptr_d;
   logic                  do_push, do_pop;

   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Next pointer values for this cycle's push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   end

   // Word storage; written on an accepted push.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/pe_result_writer.sv
// Drains PE edge-port words into a shared-memory SRAM macro.
// Each port has its own FIFO; a round-robin arbiter grants one non-empty FIFO
// per RUN cycle and the granted word is written to base+written one cycle later.
// Optional: define PE_RESULT_WRITER_STALL_CNT_EN to add the stall_cnt output.
module pe_result_writer
   import prowess_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NPORT      = 5,
   parameter int ADDR_W     = SHMEM_AW,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [ADDR_W-1:0]           base_addr,
   input  logic [ADDR_W:0]             word_count,
   input  logic [NPORT*DATA_WIDTH-1:0] port_data,
   input  logic [NPORT-1:0]            port_valid,
   output logic [NPORT-1:0]            port_ready,
   output logic                        mem_ceb,
   output logic                        mem_web,
   output logic [ADDR_W-1:0]           mem_a,
   output logic [DATA_WIDTH-1:0]       mem_d,
   output logic                        busy,
   output logic                        done,
   output logic                        err_zero
`ifdef PE_RESULT_WRITER_STALL_CNT_EN
   ,
   output logic [31:0]                 stall_cnt
`endif
);

   localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

   writer_state_e         state_q, state_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [ADDR_W:0]       count_q, count_d;
   logic [ADDR_W:0]       written_q, written_d;
   logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
   logic                  mem_ceb_q, mem_ceb_d;
   logic                  mem_web_q, mem_web_d;
   logic [ADDR_W-1:0]     mem_a_q, mem_a_d;
   logic [DATA_WIDTH-1:0] mem_d_q, mem_d_d;
   logic                  done_q, done_d;
   logic                  err_zero_q, err_zero_d;

   logic [NPORT-1:0]      fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [DATA_WIDTH-1:0] fifo_rdata [NPORT];
   logic                  can_grant, grant_valid, start_ok;
   logic [PW-1:0]         grant_idx;
   logic [PW:0]           cand;

   assign can_grant = (state_q == RUN) && (written_q != count_q);
   assign start_ok  = (state_q == IDLE) && start && (word_count != '0);

   for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
      // Ready depends on registered state only, so a full FIFO refuses even if popped this cycle.
      assign port_ready[gi] = (state_q == RUN) && !fifo_full[gi];
      assign fifo_push[gi]  = port_valid[gi] && port_ready[gi];
      assign fifo_pop[gi]   = grant_valid && (grant_idx == PW'(gi));

      pe_port_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (fifo_push[gi]),
         .wdata (port_data[gi*DATA_WIDTH +: DATA_WIDTH]),
         .pop   (fifo_pop[gi]),
         .full  (fifo_full[gi]),
         .empty (fifo_empty[gi]),
         .rdata (fifo_rdata[gi])
      );
   end

   // Round-robin: first non-empty FIFO at or after the pointer, wrapping at NPORT.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NPORT; k++) begin
         cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
         if (cand >= (PW+1)'(NPORT)) begin
            cand = cand - (PW+1)'(NPORT);
         end
         if (can_grant && !grant_valid && !fifo_empty[cand[PW-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[PW-1:0];
         end
      end
   end

   // Control state, transfer bookkeeping and the registered SRAM write port.
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      count_d    = count_q;
      written_d  = written_q;
      rr_ptr_d   = rr_ptr_q;
      mem_ceb_d  = 1'b1;
      mem_web_d  = 1'b1;
      mem_a_d    = mem_a_q;
      mem_d_d    = mem_d_q;
      done_d     = 1'b0;
      err_zero_d = err_zero_q;

      case (state_q)
         IDLE: begin
            if (start_ok) begin
               base_d     = base_addr;
               count_d    = word_count;
               written_d  = '0;
               err_zero_d = 1'b0;
               state_d    = RUN;
            end else if (start) begin
               err_zero_d = 1'b1;
            end
         end
         RUN: begin
            // The last write is on the SRAM pins this cycle; finish next.
            if (written_q == count_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant_valid) begin
         mem_ceb_d = 1'b0;
         mem_web_d = 1'b0;
         mem_a_d   = base_q + written_q[ADDR_W-1:0];
         mem_d_d   = fifo_rdata[grant_idx];
         written_d = written_q + (ADDR_W+1)'(1);
         rr_ptr_d  = (grant_idx == PW'(NPORT - 1)) ? '0 : grant_idx + PW'(1);
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         base_q     <= '0;
         count_q    <= '0;
         written_q  <= '0;
         rr_ptr_q   <= '0;
         mem_ceb_q  <= 1'b1;
         mem_web_q  <= 1'b1;
         mem_a_q    <= '0;
         mem_d_q    <= '0;
         done_q     <= 1'b0;
         err_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         count_q    <= count_d;
         written_q  <= written_d;
         rr_ptr_q   <= rr_ptr_d;
         mem_ceb_q  <= mem_ceb_d;
         mem_web_q  <= mem_web_d;
         mem_a_q    <= mem_a_d;
         mem_d_q    <= mem_d_d;
         done_q     <= done_d;
         err_zero_q <= err_zero_d;
      end
   end

   assign mem_ceb  = mem_ceb_q;
   assign mem_web  = mem_web_q;
   assign mem_a    = mem_a_q;
   assign mem_d    = mem_d_q;
   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign err_zero = err_zero_q;

`ifdef PE_RESULT_WRITER_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of RUN cycles where data waits on a port but nothing is granted.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (start_ok) begin
         stall_cnt_d = '0;
      end else if ((state_q == RUN) && !grant_valid && (|port_valid) && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
